id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register operands, immediate and PC fields.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset: synchronous and active-high, clears all state on the next rising clk edge.
REQ-004 stall_e  in  1  hold EX register contents (downstream back-pressure).
REQ-005 flush_e  in  1  replace EX contents with a bubble (taken branch/jump redirect).
REQ-006 valid_d  in  1  decode slot holds a real instruction.
REQ-007 Reg_write_d, Mem_Write_d, jump_d, Branch_d, Alu_src_d, branch_on_not_equal_d  in  1 each  decoded control bits.
REQ-008 Result_src_d  in  2  result select (00 ALU, 01 memory, 10 PC-relative).
REQ-009 ALU_Control_d  in  4  ALU operation code.
REQ-010 rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d  in  XLEN each  operands, extended immediate, PC, PC+4.
REQ-011 rs1_d, rs2_d, rd_d  in  5 each  register indices.
REQ-012 valid_e plus every *_d field above re-emitted with suffix _e  out  same widths  registered EX-stage copies.
REQ-013 load_use_hazard  out  1  combinational stall request to fetch and decode.

Function
REQ-014 Register update priority, evaluated at each rising clk edge: rst, then flush_e, then stall_e, then load_use_hazard, then normal load.
REQ-015 Normal load: every _e output takes its _d input; latency one cycle.
REQ-016 Bubble (flush_e=1, or load_use_hazard=1 with stall_e=0): all _e outputs become 0, including valid_e, Reg_write_e, Mem_Write_e, jump_e and Branch_e.
REQ-017 stall_e=1 with flush_e=0: all _e outputs hold; the decode inputs are ignored and not lost, because upstream is also held by the pipeline controller.
REQ-018 load_use_hazard = valid_e AND (Result_src_e==01) AND (rd_e!=0) AND valid_d AND ((rs1_d==rd_e) OR (rs2_d==rd_e)).
REQ-019 rs2_d is compared unconditionally regardless of instruction format; false positives are permitted, false negatives are not.
REQ-020 load_use_hazard depends only on the current _e registers and _d inputs; it is independent of stall_e and flush_e.
REQ-021 The hazard self-clears after one bubble because valid_e=0 in the following cycle; a single load therefore costs exactly one bubble.
REQ-022 flush_e and load_use_hazard asserted together: a bubble is inserted (identical result, no double effect).
REQ-023 flush_e and stall_e asserted together: the flush wins and the register becomes a bubble.
REQ-024 When valid_d=0, normal load copies the fields, but valid_e=0 and Reg_write_e/Mem_Write_e/jump_e/Branch_e are forced to 0.
REQ-025 No combinational path from any _d input to any _e output; only load_use_hazard is combinational.

Reset
REQ-026 rst=1 at a clk edge: all _e outputs become 0; load_use_hazard evaluates to 0 in the cycle after the reset edge.
REQ-027 rst asserted mid-stall or mid-hazard overrides both; there is no residual hold or bubble state after rst deasserts.
REQ-028 The block contains no state other than the EX register fields.

Verification
REQ-029 Pass-through: valid_d=1, ALU_Control_d=0001, rd1_d=0x10, rd_d=5, no stall or flush -> next cycle valid_e=1, ALU_Control_e=0001, rd1_e=0x10, rd_e=5.
REQ-030 Load-use: EX holds a load (Result_src_e=01, rd_e=7, valid_e=1) and decode has rs1_d=7 -> load_use_hazard=1 same cycle; next cycle valid_e=0, Reg_write_e=0; the cycle after that, the held instruction loads with hazard=0.
REQ-031 x0 exemption: load with rd_e=0 and rs1_d=0 -> load_use_hazard=0 and normal load occurs.
REQ-032 Stall hold: stall_e=1 for 3 cycles with changing _d inputs -> _e outputs are constant across all 3 cycles and resume loading on the first cycle after stall_e deasserts.
REQ-033 Flush priority: flush_e=1 and stall_e=1 simultaneously, EX holding a valid store -> next cycle valid_e=0, Mem_Write_e=0.
REQ-034 Reset mid-operation: rst=1 while a hazard and a stall are active -> all outputs are 0 the next cycle; after rst deasserts, normal loading resumes.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   Bundles everything that crosses the ID/EX boundary.
//   Parameter XLEN: width of operand, immediate and PC fields.
//   Pipeline control : stall_e, flush_e (from the pipeline controller)
//   Decode side (_d) : valid_d, control bits, Result_src_d, ALU_Control_d,
//                      rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d
//   Execute side (_e): registered copies of every _d field plus valid_e
//   load_use_hazard  : combinational stall request back to fetch/decode
//   master modport = the pipeline around the stage, slave modport = the stage.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic            stall_e;
  logic            flush_e;

  logic            valid_d;
  logic            Reg_write_d;
  logic            Mem_Write_d;
  logic            jump_d;
  logic            Branch_d;
  logic            Alu_src_d;
  logic            branch_on_not_equal_d;
  logic [1:0]      Result_src_d;
  logic [3:0]      ALU_Control_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] imm_ext_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [4:0]      rd_d;

  logic            valid_e;
  logic            Reg_write_e;
  logic            Mem_Write_e;
  logic            jump_e;
  logic            Branch_e;
  logic            Alu_src_e;
  logic            branch_on_not_equal_e;
  logic [1:0]      Result_src_e;
  logic [3:0]      ALU_Control_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_ext_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pc_plus4_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [4:0]      rd_e;

  logic            load_use_hazard;

  modport master (
    output stall_e, flush_e,
    output valid_d, Reg_write_d, Mem_Write_d, jump_d, Branch_d, Alu_src_d,
           branch_on_not_equal_d, Result_src_d, ALU_Control_d,
           rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
    input  valid_e, Reg_write_e, Mem_Write_e, jump_e, Branch_e, Alu_src_e,
           branch_on_not_equal_e, Result_src_e, ALU_Control_e,
           rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    input  load_use_hazard
  );

  modport slave (
    input  stall_e, flush_e,
    input  valid_d, Reg_write_d, Mem_Write_d, jump_d, Branch_d, Alu_src_d,
           branch_on_not_equal_d, Result_src_d, ALU_Control_d,
           rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
    output valid_e, Reg_write_e, Mem_Write_e, jump_e, Branch_e, Alu_src_e,
           branch_on_not_equal_e, Result_src_e, ALU_Control_e,
           rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    output load_use_hazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset, clears every EX field
//     bus  - id_ex_stage_if.slave: stall/flush controls, decode (_d) inputs,
//            registered execute (_e) outputs and the load_use_hazard request
//   Update priority each edge: rst, flush_e, stall_e, load_use_hazard, load.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  // A load in EX whose destination feeds the instruction in decode cannot
  // forward in time. rs2_d is compared even for formats without rs2; a
  // spurious bubble is harmless, a missed one is not. x0 never creates a
  // dependency.
  always_comb begin
    bus.load_use_hazard = bus.valid_e
                          && (bus.Result_src_e == 2'b01)
                          && (bus.rd_e != 5'd0)
                          && bus.valid_d
                          && ((bus.rs1_d == bus.rd_e) || (bus.rs2_d == bus.rd_e));
  end

  // Bubble when resetting, flushing, or (only if not stalled) on a hazard.
  // Flush beats stall; a stall simply leaves the register untouched.
  // Side-effecting control bits are qualified by valid_d so an empty decode
  // slot can never write registers/memory or redirect the PC.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_e || (!bus.stall_e && bus.load_use_hazard)) begin
      bus.valid_e               <= 1'b0;
      bus.Reg_write_e           <= 1'b0;
      bus.Mem_Write_e           <= 1'b0;
      bus.jump_e                <= 1'b0;
      bus.Branch_e              <= 1'b0;
      bus.Alu_src_e             <= 1'b0;
      bus.branch_on_not_equal_e <= 1'b0;
      bus.Result_src_e          <= 2'b00;
      bus.ALU_Control_e         <= 4'b0000;
      bus.rd1_e                 <= XLEN'(0);
      bus.rd2_e                 <= XLEN'(0);
      bus.imm_ext_e             <= XLEN'(0);
      bus.pc_e                  <= XLEN'(0);
      bus.pc_plus4_e            <= XLEN'(0);
      bus.rs1_e                 <= 5'd0;
      bus.rs2_e                 <= 5'd0;
      bus.rd_e                  <= 5'd0;
    end else if (!bus.stall_e) begin
      bus.valid_e               <= bus.valid_d;
      bus.Reg_write_e           <= bus.valid_d && bus.Reg_write_d;
      bus.Mem_Write_e           <= bus.valid_d && bus.Mem_Write_d;
      bus.jump_e                <= bus.valid_d && bus.jump_d;
      bus.Branch_e              <= bus.valid_d && bus.Branch_d;
      bus.Alu_src_e             <= bus.Alu_src_d;
      bus.branch_on_not_equal_e <= bus.branch_on_not_equal_d;
      bus.Result_src_e          <= bus.Result_src_d;
      bus.ALU_Control_e         <= bus.ALU_Control_d;
      bus.rd1_e                 <= bus.rd1_d;
      bus.rd2_e                 <= bus.rd2_d;
      bus.imm_ext_e             <= bus.imm_ext_d;
      bus.pc_e                  <= bus.pc_d;
      bus.pc_plus4_e            <= bus.pc_plus4_d;
      bus.rs1_e                 <= bus.rs1_d;
      bus.rs2_e                 <= bus.rs2_d;
      bus.rd_e                  <= bus.rd_d;
    end
  end

endmodule
